// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Step counter width: enough bits to hold the value WIDTH.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor with an adder (R' + ~B + 1), and keep or restore the result.
module div_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] r_i,
   input  logic             d_msb_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] r_next_o,
   output logic             qbit_o
);

   logic [WIDTH:0] r_sh_s;
   logic [WIDTH:0] t_s;

   // Trial subtraction; the top bit of t_s is the borrow. The kept remainder
   // is always below the divisor, so it fits back into WIDTH bits.
   always_comb begin
      r_sh_s = {r_i, d_msb_i};
      t_s    = r_sh_s + ~{1'b0, b_i} + {{WIDTH{1'b0}}, 1'b1};
      if (t_s[WIDTH] == 1'b0) begin
         r_next_o = t_s[WIDTH-1:0];
         qbit_o   = 1'b1;
      end else begin
         r_next_o = r_sh_s[WIDTH-1:0];
         qbit_o   = 1'b0;
      end
   end

endmodule

// File: rtl/div4_seq.sv
// Sequential unsigned restoring divider with start/done handshake.
// One quotient bit per clock, MSB first; divide-by-zero finishes in one cycle.
module div4_seq
   import div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done,
   output logic             div0
);

   localparam int CW = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] q_out_q, q_out_d;
   logic [WIDTH-1:0] r_out_q, r_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div0_q, div0_d;

   logic [WIDTH-1:0] rem_next_s;
   logic             qbit_s;

   div_step #(.WIDTH(WIDTH)) u_step (
      .r_i      (rem_q),
      .d_msb_i  (dvd_q[WIDTH-1]),
      .b_i      (dvs_q),
      .r_next_o (rem_next_s),
      .qbit_o   (qbit_s)
   );

   // Next-state, datapath and output-register update logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      q_out_d = q_out_q;
      r_out_d = r_out_q;
      div0_d  = div0_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               dvd_d = a;
               rem_d = {WIDTH{1'b0}};
               dvs_d = b;
               cnt_d = {CW{1'b0}};
               if (b != {WIDTH{1'b0}}) begin
                  state_d = RUN;
                  busy_d  = 1'b1;
                  div0_d  = 1'b0;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  div0_d  = 1'b1;
                  q_out_d = {WIDTH{1'b1}};
                  r_out_d = a;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            dvd_d = {dvd_q[WIDTH-2:0], qbit_s};
            rem_d = rem_next_s;
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            // Results leave straight from the last step so done lines up with q/r.
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
               q_out_d = {dvd_q[WIDTH-2:0], qbit_s};
               r_out_d = rem_next_s;
            end else begin
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= {CW{1'b0}};
         dvd_q   <= {WIDTH{1'b0}};
         rem_q   <= {WIDTH{1'b0}};
         dvs_q   <= {WIDTH{1'b0}};
         q_out_q <= {WIDTH{1'b0}};
         r_out_q <= {WIDTH{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         q_out_q <= q_out_d;
         r_out_q <= r_out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         div0_q  <= div0_d;
      end
   end

   assign q    = q_out_q;
   assign r    = r_out_q;
   assign busy = busy_q;
   assign done = done_q;
   assign div0 = div0_q;

endmodule
